// File: rtl/tiny_dnn_pkg.sv
// Shared types and constants for the tiny_dnn_array bfloat16 dot-product array.
package tiny_dnn_pkg;

  localparam int BF16_BIAS = 127;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] frac;
  } bf16_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

endpackage

// File: rtl/tiny_dnn_if.sv
// Activation stream (valid/ready) into the dot-product array.
interface tiny_dnn_if;
  import tiny_dnn_pkg::*;

  logic  s_valid;
  logic  s_ready;
  bf16_t s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/tiny_dnn_mac.sv
// One channel: weight RAM, stage-1 operand registers and an fp32 fused accumulate.
module tiny_dnn_mac
  import tiny_dnn_pkg::*;
#(
  parameter int F_SIZE = 512,
  localparam int IW = $clog2(F_SIZE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wr_en,
  input  logic [IW-1:0] i_wr_idx,
  input  bf16_t         i_wr_data,
  input  logic [IW-1:0] i_rd_idx,
  input  logic          i_fire,
  input  bf16_t         i_act,
  input  logic          i_clear,
  input  logic          i_relu,
  output fp32_t         o_sum
);

  bf16_t r_mem [F_SIZE];
  bf16_t r_w;
  bf16_t r_a;
  logic  r_v;
  fp32_t r_sum;

  // Sum significand is 15 bits (hidden 1 + frac[22:9]); both operands are aligned
  // into a 2.14 fixed-point frame at the larger exponent, truncating shifted-out bits.
  function automatic fp32_t fma(fp32_t acc, bf16_t w, bf16_t a);
    logic        [15:0] prod;
    logic        [15:0] p_al;
    logic        [15:0] s_al;
    logic        [16:0] mag;
    logic        [16:0] norm;
    logic signed [9:0]  pe;
    logic signed [9:0]  se;
    logic signed [9:0]  d;
    logic signed [9:0]  nd;
    logic signed [9:0]  e_ref;
    logic signed [9:0]  ne;
    logic        [4:0]  lz;
    logic               p_sgn;
    logic               sgn;
    logic               found;
    fp32_t              res;
    // NOTE: every local gets a value up front so no path leaves anything unassigned.
    res   = acc;
    prod  = {1'b1, w.frac} * {1'b1, a.frac};
    p_sgn = w.sign ^ a.sign;
    pe    = $signed({2'b00, w.exp}) + $signed({2'b00, a.exp}) - 10'(BF16_BIAS);
    se    = $signed({2'b00, acc.exp});
    d     = se - pe;
    nd    = pe - se;
    p_al  = prod;
    s_al  = '0;
    e_ref = pe;
    mag   = '0;
    norm  = '0;
    ne    = '0;
    lz    = '0;
    sgn   = 1'b0;
    found = 1'b0;
    if (pe > 0 && !(acc.exp != 8'd0 && d > 10'sd16)) begin
      if (acc.exp != 8'd0) begin
        if (d >= 0) begin
          p_al  = prod >> d[4:0];
          s_al  = {2'b01, acc.frac[22:9]};
          e_ref = se;
        end else begin
          s_al  = (nd >= 10'sd16) ? 16'd0 : ({2'b01, acc.frac[22:9]} >> nd[4:0]);
        end
      end
      if (p_sgn == acc.sign) begin
        mag = {1'b0, p_al} + {1'b0, s_al};
        sgn = p_sgn;
      end else if (p_al >= s_al) begin
        mag = {1'b0, p_al - s_al};
        sgn = p_sgn;
      end else begin
        mag = {1'b0, s_al - p_al};
        sgn = acc.sign;
      end
      for (int i = 16; i >= 0; i--) begin
        if (!found && mag[i]) begin
          lz    = 5'(16 - i);
          found = 1'b1;
        end
      end
      norm = mag << lz;
      ne   = e_ref + 10'sd2 - $signed({5'b00000, lz});
      if (!found || ne <= 0) res = '0;
      else                   res = {sgn, ne[7:0], norm[15:2], 9'd0};
    end
    return res;
  endfunction

  // NOTE: the weight RAM and operand registers carry no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_idx] <= i_wr_data;
    if (i_fire) begin
      r_w <= r_mem[i_rd_idx];
      r_a <= i_act;
    end
  end

  // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) r_v <= 1'b0;
    else        r_v <= i_fire;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                    r_sum <= '0;
    else if (i_clear)              r_sum <= '0;
    else if (r_v)                  r_sum <= fma(r_sum, r_w, r_a);
    else if (i_relu && r_sum.sign) r_sum <= '0;
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/tiny_dnn_array.sv
// F_NUM-channel bfloat16 dot-product array: pass sequencer, weight write decode and readout.
module tiny_dnn_array
  import tiny_dnn_pkg::*;
#(
  parameter int F_NUM  = 16,
  parameter int F_SIZE = 512,
  localparam int CW = $clog2(F_NUM),
  localparam int IW = $clog2(F_SIZE)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [CW+IW-1:0] wr_addr,
  input  logic [15:0]     wr_data,
  input  logic            start,
  input  logic [IW:0]     len,
  input  logic            relu,
  tiny_dnn_if.slave       s_if,
  output logic            busy,
  output logic            done,
  input  logic [CW-1:0]   rd_addr,
  output logic [31:0]     rd_data
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] RUN   = ST_RUN;
  localparam logic [1:0] DRAIN = ST_DRAIN;
  localparam logic [1:0] FIN   = ST_FIN;

  logic [1:0]    r_state;
  logic [IW-1:0] r_k;
  logic [IW:0]   r_len;
  logic          r_relu;
  logic [31:0]   r_rd_data;

  logic          w_fire;
  logic          w_last;
  logic          w_clear;
  logic          w_relu_apply;
  logic          w_wr_ok;
  logic [F_NUM-1:0] w_wr_sel;
  fp32_t         w_sum [F_NUM];

  assign s_if.s_ready = (r_state == RUN);
  assign w_fire       = s_if.s_valid && (r_state == RUN);
  assign w_last       = ({1'b0, r_k} == r_len - 1'b1);
  assign w_clear      = (r_state == IDLE) && start;
  assign w_relu_apply = (r_state == FIN) && r_relu;
  assign w_wr_ok      = wr_en && (r_state == IDLE);

  assign busy    = (r_state != IDLE);
  assign done    = (r_state == FIN);
  assign rd_data = r_rd_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_len   <= '0;
      r_relu  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_len   <= len;
          r_relu  <= relu;
          r_k     <= '0;
          r_state <= (len == '0) ? DRAIN : RUN;
        end
        RUN: if (w_fire) begin
          r_k <= r_k + 1'b1;
          if (w_last) r_state <= DRAIN;
        end
        DRAIN:   r_state <= FIN;
        FIN:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Readout tracks rd_addr only in IDLE, so it freezes on the pre-pass value while busy.
  always_ff @(posedge clk) begin
    if (!rst_n)                r_rd_data <= '0;
    else if (r_state == IDLE)  r_rd_data <= w_sum[rd_addr];
  end

  for (genvar c = 0; c < F_NUM; c++) begin : g_ch
    assign w_wr_sel[c] = w_wr_ok && (wr_addr[CW+IW-1:IW] == CW'(c));

    tiny_dnn_mac #(.F_SIZE(F_SIZE)) u_mac (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr_en   (w_wr_sel[c]),
      .i_wr_idx  (wr_addr[IW-1:0]),
      .i_wr_data (wr_data),
      .i_rd_idx  (r_k),
      .i_fire    (w_fire),
      .i_act     (s_if.s_data),
      .i_clear   (w_clear),
      .i_relu    (w_relu_apply),
      .o_sum     (w_sum[c])
    );
  end

endmodule

// File: tb/tb_tiny_dnn_array.sv
// Randomised self-checking bench for tiny_dnn_array against an integer-arithmetic reference.
module tb_tiny_dnn_array;

  localparam int F_NUM  = 4;
  localparam int F_SIZE = 8;
  localparam int CW = $clog2(F_NUM);
  localparam int IW = $clog2(F_SIZE);
  localparam int LW = IW + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            wr_en = 1'b0;
  logic [CW+IW-1:0] wr_addr = '0;
  logic [15:0]     wr_data = '0;
  logic            start = 1'b0;
  logic [IW:0]     len = '0;
  logic            relu = 1'b0;
  logic            busy;
  logic            done;
  logic [CW-1:0]   rd_addr = '0;
  logic [31:0]     rd_data;

  tiny_dnn_if s_if ();

  always #5 clk = ~clk;

  tiny_dnn_array #(.F_NUM(F_NUM), .F_SIZE(F_SIZE)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .len     (len),
    .relu    (relu),
    .s_if    (s_if),
    .busy    (busy),
    .done    (done),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] m_w  [F_NUM][F_SIZE];
  logic [31:0] m_sum [F_NUM];
  logic [15:0] acts [F_SIZE];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference: exact integer product, aligned by integer shifts, renormalised by loop.
  function automatic logic [31:0] ref_fma(logic [31:0] s, logic [15:0] w, logic [15:0] a);
    int     pe, se, e;
    longint pm, sm, v, m;
    bit     neg;
    pe = int'(w[14:7]) + int'(a[14:7]) - 127;
    if (pe <= 0) return s;
    se = int'(s[30:23]);
    if (se != 0 && se - pe > 16) return s;
    pm = longint'({1'b1, w[6:0]}) * longint'({1'b1, a[6:0]});
    sm = (se == 0) ? 0 : longint'({1'b1, s[22:9]});
    e  = (se > pe) ? se : pe;
    pm = pm >> (e - pe);
    sm = (e - se >= 32) ? 0 : (sm >> (e - se));
    v  = ((w[15] ^ a[15]) ? -pm : pm) + (s[31] ? -sm : sm);
    neg = (v < 0);
    m   = neg ? -v : v;
    if (m == 0) return 32'd0;
    while (m >= 32768) begin m = m >> 1; e++; end
    while (m < 16384)  begin m = m << 1; e--; end
    if (e <= 0) return 32'd0;
    return {neg, 8'(e), 14'(m), 9'd0};
  endfunction

  function automatic logic [15:0] rnd_bf16();
    logic [15:0] v;
    v[15]   = 1'($urandom_range(0, 1));
    v[14:7] = 8'(120 + $urandom_range(0, 14));
    v[6:0]  = 7'($urandom);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_w(input int c, input int i, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = {CW'(c), IW'(i)};
    wr_data = d;
    step();
    wr_en   = 1'b0;
    m_w[c][i] = d;
  endtask

  task automatic read_all(input string tag);
    for (int c = 0; c < F_NUM; c++) begin
      rd_addr = CW'(c);
      step();
      check(tag, rd_data, m_sum[c]);
    end
  endtask

  task automatic read_one(input string tag, input int c, input logic [31:0] exp);
    rd_addr = CW'(c);
    step();
    check(tag, rd_data, exp);
  endtask

  // gap < 0 picks a random 0..3 idle cycles before each later beat; abort_at >= 0 resets before that beat.
  task automatic run_pass(input int n, input bit rl, input int gap, input bit busy_wr, input int abort_at);
    logic [31:0] hold_exp;
    int          lat;
    int          tmo;
    int          g;
    hold_exp = m_sum[rd_addr];
    start = 1'b1;
    len   = LW'(n);
    relu  = rl;
    step();
    start = 1'b0;
    check("busy_rise", busy, 1);
    check("s_ready_after_start", s_if.s_ready, (n != 0));
    if (busy_wr) begin
      wr_en   = 1'b1;
      wr_addr = '0;
      wr_data = 16'h4000;
      step();
      wr_en   = 1'b0;
    end
    for (int j = 0; j < n; j++) begin
      g = (j == 0) ? 0 : ((gap < 0) ? $urandom_range(0, 3) : gap);
      repeat (g) begin
        s_if.s_valid = 1'b0;
        s_if.s_data  = 16'($urandom);
        step();
        check("s_ready_gap", s_if.s_ready, 1);
      end
      if (abort_at == j) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("abort_busy", busy, 0);
        check("abort_rd_data", rd_data, 0);
        check("abort_done", done, 0);
        check("abort_s_ready", s_if.s_ready, 0);
        for (int c = 0; c < F_NUM; c++) m_sum[c] = '0;
        return;
      end
      s_if.s_valid = 1'b1;
      s_if.s_data  = acts[j];
      tmo = 0;
      while (!s_if.s_ready && tmo < 8) begin step(); tmo++; end
      check("s_ready_run", s_if.s_ready, 1);
      step();
      s_if.s_valid = 1'b0;
    end
    check("s_ready_drain", s_if.s_ready, 0);
    check("rd_hold", rd_data, hold_exp);
    lat = 1;
    while (done !== 1'b1 && lat < 10) begin step(); lat++; end
    check("done_latency", 32'(lat), 2);
    step();
    check("busy_fall", busy, 0);
    check("done_single", done, 0);
    for (int c = 0; c < F_NUM; c++) begin
      m_sum[c] = '0;
      for (int j = 0; j < n; j++) m_sum[c] = ref_fma(m_sum[c], m_w[c][j], acts[j]);
      if (rl && m_sum[c][31]) m_sum[c] = '0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    for (int c = 0; c < F_NUM; c++) m_sum[c] = '0;

    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_s_ready", s_if.s_ready, 0);
    check("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;
    step();

    // All weights 1.0, four beats of 2.0 -> 8.0 everywhere.
    for (int c = 0; c < F_NUM; c++)
      for (int i = 0; i < F_SIZE; i++) wr_w(c, i, 16'h3F80);
    for (int j = 0; j < F_SIZE; j++) acts[j] = 16'h4000;
    run_pass(4, 1'b0, 0, 1'b0, -1);
    read_all("ones_x2");
    read_one("ones_x2_lit", 2, 32'h41000000);

    // Channel 3 negative, with and without ReLU; then the same with stalls.
    for (int j = 0; j < 3; j++) wr_w(3, j, 16'hBF80);
    for (int j = 0; j < F_SIZE; j++) acts[j] = 16'h3F80;
    run_pass(3, 1'b0, 0, 1'b0, -1);
    read_all("neg_ch3");
    read_one("neg_ch3_lit", 3, 32'hC0400000);
    run_pass(3, 1'b1, 0, 1'b0, -1);
    read_all("neg_ch3_relu");
    read_one("neg_ch3_relu_lit", 3, 32'h00000000);
    run_pass(3, 1'b0, 5, 1'b0, -1);
    read_all("neg_ch3_gaps");
    read_one("neg_ch3_gaps_lit", 3, 32'hC0400000);

    // Empty pass.
    run_pass(0, 1'b0, 0, 1'b0, -1);
    read_all("len0");
    read_one("len0_lit", 1, 32'h00000000);

    // Reset mid-pass, then confirm weights survive.
    for (int j = 0; j < F_SIZE; j++) acts[j] = 16'h4000;
    run_pass(4, 1'b0, 0, 1'b0, 2);
    step();
    check("abort_no_done", done, 0);
    read_all("abort_cleared");
    run_pass(4, 1'b0, 0, 1'b0, -1);
    read_all("after_abort");
    read_one("after_abort_lit", 0, 32'h41000000);

    // Weight write while busy must be dropped; rerun back-to-back.
    wr_w(0, 0, 16'h3F80);
    acts[0] = 16'h3F80;
    run_pass(1, 1'b0, 0, 1'b1, -1);
    run_pass(1, 1'b0, 0, 1'b0, -1);
    read_one("busy_wr_lit", 0, 32'h3F800000);
    read_all("busy_wr");

    // Randomised passes, first at the full vector length.
    for (int r = 0; r < 6; r++) begin
      n = (r == 0) ? F_SIZE : $urandom_range(1, F_SIZE);
      for (int c = 0; c < F_NUM; c++)
        for (int j = 0; j < n; j++) wr_w(c, j, rnd_bf16());
      for (int j = 0; j < n; j++) acts[j] = rnd_bf16();
      run_pass(n, 1'($urandom_range(0, 1)), -1, 1'b0, -1);
      read_all($sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tiny_dnn_array.md
# tiny_dnn_array

Parametrised successor to the 16-channel bfloat16 dot-product array in the MNIST example. It holds F_NUM × F_SIZE bfloat16 weights and accepts a valid/ready stream of bfloat16 activations. Each accepted activation is broadcast to every channel and multiplied by that channel's weight at an auto-incremented index, then accumulated into a per-channel fp32 sum through a registered 2-stage pipeline. A sequencing FSM runs the whole pass from a single `start` and applies an optional ReLU at the end. Sums are then read back one channel per address.

## Interface
- F_NUM, 16, channel count (power of 2, ≥2)
- F_SIZE, 512, weights per channel / maximum vector length (power of 2)
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- wr_en  in  1  weight write strobe
- wr_addr  in  log2(F_NUM)+log2(F_SIZE)  {channel, index}; channel in the MSBs
- wr_data  in  16  bfloat16 weight
- start  in  1  begin a pass (accepted only in IDLE)
- len  in  log2(F_SIZE)+1  vector length for the pass, 0..F_SIZE
- relu  in  1  clamp negative sums to 0 at the end of the pass
- s_valid  in  1  activation valid
- s_ready  out  1  activation ready
- s_data  in  16  bfloat16 activation
- busy  out  1  FSM not IDLE
- done  out  1  one-cycle pulse when the pass completes
- rd_addr  in  log2(F_NUM)  channel to read
- rd_data  out  32  fp32 sum, registered

## Operation
- FSM states: IDLE, RUN, DRAIN, FIN.
- IDLE + start:
  - latch len and relu; clear all sums to 0; set k=0.
  - len≠0 → RUN; len=0 → DRAIN.
- RUN:
  - s_ready=1.
  - Each cycle with s_valid&s_ready: stage 1 registers W[c][k] for every channel c, plus s_data and a valid bit; k increments.
  - The beat at which k reaches len-1 goes to DRAIN.
- DRAIN:
  - s_ready=0.
  - Stage 2 accumulates the final beat → FIN.
- FIN:
  - if relu, every sum with sign=1 is set to 0.
  - done=1 → IDLE.
- Stage 2 (each channel, when stage-1 valid): sum ← fma(sum, w, a).
- fma arithmetic:
  - 8×8 significand product with hidden 1s; product exponent = ew+ea-127.
  - Alignment is against the sum's 15-bit significand.
  - Product exponent ≤0 → sum unchanged.
  - Sum exponent exceeds product exponent by >16 → sum unchanged.
  - Sum exponent 0 is treated as zero.
  - Normalise by leading-zero count; normalised exponent ≤0 → +0.
  - Truncate, no rounding; result bits [8:0] always 0.
- Weight writes are accepted in IDLE only and ignored while busy: W[wr_addr[MSBs]][wr_addr[LSBs]] ← wr_data.
- start while busy is ignored.
- rd_data ← sum[rd_addr] every cycle in IDLE; it holds its value while busy.
- Simultaneous wr_en and start in IDLE: the write lands and the pass starts. Stage 1 reads W on the following cycle or later, so the new weight is visible to the pass.

## Timing
- Reset values: state IDLE, all sums 0, rd_data 0, s_ready 0, busy 0, done 0, k 0, stage-1 valid 0.
- rst_n low mid-pass aborts the pass: no done pulse, sums cleared.
- busy rises the cycle after start is sampled.
- s_ready rises the cycle after start is sampled when len≠0.
- done pulses exactly 2 cycles after the last accepted beat (DRAIN, then FIN).
- With len=0, done pulses 2 cycles after start.
- rd_data is valid 1 cycle after rd_addr is presented in IDLE.
- After done, the first valid read is on the cycle following the return to IDLE.
- s_valid gaps stall k and the pipeline without loss.
- Back-to-back passes: start may be asserted in the cycle after done.

## Structure
- Package tiny_dnn_pkg:
  - bf16_t and fp32_t packed typedefs with sign/exp/frac fields.
  - BF16_BIAS=127.
  - FSM state enum.
- Sub-module tiny_dnn_mac, one per channel (generate loop), contains:
  - weight RAM (F_SIZE×16, single read port);
  - stage-1 registers;
  - fp32 accumulator;
  - combinational fma function.
- The top level holds the FSM, the k counter, write decode and the readout mux.

## Test plan
- All weights 0x3F80 (1.0), len=4, four beats of 0x4000 (2.0) → every channel reads 0x41000000 (8.0); done exactly 2 cycles after the 4th beat.
- Channel 3 weights 0xBF80 (-1.0), len=3, activations 0x3F80:
  - relu=0 → rd_data[3]=0xC0400000 (-3.0);
  - relu=1 → 0x00000000.
- len=3 with s_valid low for 5 cycles between beats → same sums as the gap-free run; s_ready stays high throughout RUN.
- len=0 → done 2 cycles after start, all sums 0x00000000, s_ready never asserted.
- rst_n low in the middle of RUN:
  - no done pulse;
  - busy=0 and rd_data=0 on the next cycle;
  - weights written before the pass are still readable in the next pass.
- wr_en during busy to {channel 0, index 0} with 0x4000 is ignored: a rerun with weight 1.0 and activation 1.0, len=1 → 0x3F800000.
